down_counter16: RTL

DOWN_COUNTER16 -- requirements
Module: down_counter16

---
 rtl/dcnt_pkg.sv | 15 +
 rtl/dcnt_slice.sv | 18 +
 rtl/down_counter16.sv | 104 ++++++++++
 3 files changed

// File: rtl/dcnt_pkg.sv
// Shared types and defaults for the sliced down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcnt_pkg;

    localparam int DCNT_WIDTH   = 16;
    localparam int DCNT_SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } dcnt_state_e;

endpackage

// File: rtl/dcnt_slice.sv
// One slice of the decrement borrow chain: q = d - borrow_in.
// Latency: combinational.
// Backpressure: none; the borrow ripples to the next slice.
module dcnt_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] d,
    input  logic         borrow_in,
    output logic [W-1:0] q,
    output logic         borrow_out,
    output logic         zero_o
);

    assign zero_o     = (d == '0);
    assign q          = d - {{(W-1){1'b0}}, borrow_in};
    assign borrow_out = borrow_in & zero_o;

endmodule

// File: rtl/down_counter16.sv
// Loadable down counter with IDLE/RUN/EXPIRED control and optional auto-reload.
// Latency: one cycle per decrement; expired_o registered one cycle after the step.
// Backpressure: counting stalls whenever enp_i or ent_i is low.
module down_counter16
    import dcnt_pkg::*;
#(
    parameter int WIDTH   = DCNT_WIDTH,
    parameter int SLICE_W = DCNT_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             enp_i,
    input  logic             ent_i,
    input  logic             start_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             borrow_o,
    output logic             expired_o,
    output logic             busy_o
);

    localparam int N_SLICE = WIDTH / SLICE_W;

    dcnt_state_e      state_q, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] dec_val;
    logic             expired_q, expired_nxt;

    logic [N_SLICE:0]   borrow_chain;
    logic [N_SLICE-1:0] slice_zero;
    logic               count_zero;
    logic               underflow;
    logic               step;

    assign borrow_chain[0] = 1'b1;

    for (genvar g = 0; g < N_SLICE; g++) begin : g_slice
        dcnt_slice #(
            .W (SLICE_W)
        ) u_slice (
            .d          (count_q[g*SLICE_W +: SLICE_W]),
            .borrow_in  (borrow_chain[g]),
            .q          (dec_val[g*SLICE_W +: SLICE_W]),
            .borrow_out (borrow_chain[g+1]),
            .zero_o     (slice_zero[g])
        );
    end

    assign count_zero = &slice_zero;
    // A borrow escaping the top slice means this step would wrap: that is expiry.
    assign underflow  = borrow_chain[N_SLICE];
    assign step       = (state_q == RUN) && enp_i && ent_i;

    always_comb begin
        state_nxt   = state_q;
        count_nxt   = count_q;
        expired_nxt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_nxt = RUN;
            end
            RUN: begin
                if (step && underflow) begin
                    expired_nxt = 1'b1;
                    if (auto_reload_i) count_nxt = reload_q;
                    else               state_nxt = EXPIRED;
                end else if (step) begin
                    count_nxt = dec_val;
                end
            end
            EXPIRED: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A load wins over any step taken in the same cycle, including an expiry.
        if (load_i) begin
            count_nxt   = load_val_i;
            expired_nxt = 1'b0;
            if (state_q == RUN) state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            count_q   <= count_nxt;
            expired_q <= expired_nxt;
            if (load_i) reload_q <= load_val_i;
        end
    end

    assign count_o   = count_q;
    assign borrow_o  = ent_i & count_zero;
    assign expired_o = expired_q;
    assign busy_o    = (state_q == RUN);

endmodule
